// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the core sequencer: FSM state encodings, RV32I
// major opcodes, register-file write-source and ALU-mode encodings, and an
// opcode legality helper used by the decode step.
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Register-file write source
  localparam logic [1:0] RD_PC_ALU = 2'd0;
  localparam logic [1:0] RD_ALU    = 2'd1;
  localparam logic [1:0] RD_MEM    = 2'd2;

  // ALU operating mode
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_FUNC  = 2'd1;
  localparam logic [1:0] ALU_CMP   = 2'd2;

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_sequencer_branch_resolve.sv
// Combinational branch condition resolver.
// Ports:
//   func3_i    branch kind (instruction[14:12])
//   eq_i       rs1 == rs2
//   a_lt_b_i   rs1 < rs2 (signed)
//   a_lt_ub_i  rs1 < rs2 (unsigned)
//   taken_o    branch condition holds
//   illegal_o  func3 does not name a branch (010/011)
module core_sequencer_branch_resolve (
  input  logic [2:0] func3_i,
  input  logic       eq_i,
  input  logic       a_lt_b_i,
  input  logic       a_lt_ub_i,
  output logic       taken_o,
  output logic       illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (func3_i)
      3'b000:  taken_o = eq_i;
      3'b001:  taken_o = !eq_i;
      3'b100:  taken_o = a_lt_b_i;
      3'b101:  taken_o = !a_lt_b_i;
      3'b110:  taken_o = a_lt_ub_i;
      3'b111:  taken_o = !a_lt_ub_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multicycle sequencer for a single-ported RV32I datapath.
// Walks FETCH -> DECODE -> EXEC [-> MEM [-> WB]] and emits one-cycle load
// strobes instead of gated clocks. The one memory port is shared between
// instruction fetch (PC address) and load/store (ALU address) through a
// req/ready handshake. Also provides halt, a sticky illegal-instruction trap
// and free-running cycle / retired-instruction counters.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   opcode, func3                  fields of the held instruction
//   eq, a_lt_b, a_lt_ub            ALU compare flags
//   mem_ready, halt_req            memory completion, halt request
//   insn_en, pc_en, rd_en          load strobes (IR, PC, register file)
//   mem_req, mem_we, addr_sel      memory request controls
//   rd_sel, alu_a_sel, alu_b_sel,
//   alu_mode, pc_alu_sel,
//   pc_next_sel, sx_size           datapath mux/mode selects
//   halted, trap, state            status
//   cycle_cnt, instret_cnt         wrapping counters
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic             eq,
  input  logic             a_lt_b,
  input  logic             a_lt_ub,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             insn_en,
  output logic             pc_en,
  output logic             rd_en,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic [1:0]       rd_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       alu_mode,
  output logic             pc_alu_sel,
  output logic             pc_next_sel,
  output logic [2:0]       sx_size,
  output logic             halted,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_e           state_q, state_d;
  // A fetch request is outstanding; halt may only be taken before one starts
  logic             fetch_pend_q, fetch_pend_d;
  // HALT was entered through ECALL/EBREAK and is left only by reset
  logic             halt_sys_q, halt_sys_d;
  logic [CNT_W-1:0] cycle_q, instret_q;

  logic br_taken, br_illegal;
  logic is_store, is_load, is_system;
  logic halt_now;

  assign is_store  = (opcode == OPC_STORE);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_system = (opcode == OPC_SYSTEM);
  assign halt_now  = !fetch_pend_q && halt_req;

  core_sequencer_branch_resolve u_branch (
    .func3_i   (func3),
    .eq_i      (eq),
    .a_lt_b_i  (a_lt_b),
    .a_lt_ub_i (a_lt_ub),
    .taken_o   (br_taken),
    .illegal_o (br_illegal)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      fetch_pend_q <= 1'b0;
      halt_sys_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pend_q <= fetch_pend_d;
      halt_sys_q   <= halt_sys_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    fetch_pend_d = fetch_pend_q;
    halt_sys_d   = halt_sys_q;
    case (state_q)
      ST_FETCH: begin
        if (halt_now) begin
          state_d    = ST_HALT;
          halt_sys_d = 1'b0;
        end else if (mem_ready) begin
          state_d      = ST_DECODE;
          fetch_pend_d = 1'b0;
        end else begin
          fetch_pend_d = 1'b1;
        end
      end
      ST_DECODE: begin
        if (!opcode_legal(opcode) || ((opcode == OPC_BRANCH) && br_illegal))
          state_d = ST_TRAP;
        else
          state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_load || is_store) begin
          state_d = ST_MEM;
        end else if (is_system) begin
          state_d    = ST_HALT;
          halt_sys_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (mem_ready) state_d = is_store ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: begin
        if (!halt_sys_q && !halt_req) state_d = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    insn_en     = 1'b0;
    pc_en       = 1'b0;
    rd_en       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    rd_sel      = RD_PC_ALU;
    alu_a_sel   = 1'b0;
    alu_b_sel   = 1'b0;
    alu_mode    = ALU_ADD;
    pc_alu_sel  = 1'b1;
    pc_next_sel = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = !halt_now;
        insn_en = !halt_now && mem_ready;
      end
      ST_EXEC: begin
        case (opcode)
          OPC_OP, OPC_OPIMM: begin
            rd_en     = 1'b1;
            rd_sel    = RD_ALU;
            alu_mode  = ALU_FUNC;
            alu_b_sel = (opcode == OPC_OPIMM);
            pc_en     = 1'b1;
          end
          OPC_LUI, OPC_AUIPC: begin
            rd_en     = 1'b1;
            rd_sel    = RD_ALU;
            alu_b_sel = 1'b1;
            alu_a_sel = (opcode == OPC_AUIPC);
            pc_en     = 1'b1;
          end
          // Target from the ALU, link value from the PC adder, both on one edge
          OPC_JAL, OPC_JALR: begin
            alu_a_sel   = (opcode == OPC_JAL);
            alu_b_sel   = 1'b1;
            pc_next_sel = 1'b1;
            rd_en       = 1'b1;
            rd_sel      = RD_PC_ALU;
            pc_en       = 1'b1;
          end
          OPC_BRANCH: begin
            alu_mode   = ALU_CMP;
            pc_en      = 1'b1;
            pc_alu_sel = !br_taken;
          end
          OPC_LOAD, OPC_STORE: alu_b_sel = 1'b1;
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        mem_we    = is_store;
        alu_b_sel = 1'b1;
        pc_en     = is_store && mem_ready;
      end
      ST_WB: begin
        rd_en  = 1'b1;
        rd_sel = RD_MEM;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      insn_en = 1'b0;
      pc_en   = 1'b0;
      rd_en   = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      if (pc_en) instret_q <= instret_q + 1'b1;
    end
  end

  assign sx_size     = ((state_q == ST_MEM) || (state_q == ST_WB)) ? func3 : 3'd0;
  assign halted      = (state_q == ST_HALT);
  assign trap        = (state_q == ST_TRAP);
  assign state       = state_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer. Each instruction is expanded into a timeline of
// expected per-cycle control vectors from its class and wait states, then
// replayed against the design cycle by cycle.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, eq, a_lt_b, a_lt_ub, mem_ready, halt_req;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        insn_en, pc_en, rd_en, mem_req, mem_we, addr_sel;
  logic [1:0]  rd_sel, alu_mode;
  logic        alu_a_sel, alu_b_sel, pc_alu_sel, pc_next_sel, halted, trap;
  logic [2:0]  sx_size, state;
  logic [31:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  core_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3),
    .eq(eq), .a_lt_b(a_lt_b), .a_lt_ub(a_lt_ub),
    .mem_ready(mem_ready), .halt_req(halt_req),
    .insn_en(insn_en), .pc_en(pc_en), .rd_en(rd_en),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .rd_sel(rd_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_mode(alu_mode), .pc_alu_sel(pc_alu_sel), .pc_next_sel(pc_next_sel),
    .sx_size(sx_size), .halted(halted), .trap(trap), .state(state),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  typedef struct packed {
    logic       ie, pe, re, mq, mw, as;
    logic [1:0] rs;
    logic       aa, ab;
    logic [1:0] am;
    logic       pas, pns;
    logic [2:0] sx;
    logic       h, t;
    logic [2:0] st;
  } vec_t;

  typedef struct {
    vec_t v;
    vec_t m;
    logic rdy;
    logic hr;
  } cyc_t;

  cyc_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_cyc, exp_ret;
  logic [6:0]  legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                  7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                                  7'b0100011, 7'b1110011};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic vec_t base_mask();
    vec_t m;
    m = '0;
    {m.ie, m.pe, m.re, m.mq, m.mw} = '1;
    m.sx = '1; m.h = 1'b1; m.t = 1'b1; m.st = '1;
    return m;
  endfunction

  function automatic vec_t observe();
    vec_t o;
    o.ie = insn_en; o.pe = pc_en; o.re = rd_en; o.mq = mem_req; o.mw = mem_we;
    o.as = addr_sel; o.rs = rd_sel; o.aa = alu_a_sel; o.ab = alu_b_sel;
    o.am = alu_mode; o.pas = pc_alu_sel; o.pns = pc_next_sel; o.sx = sx_size;
    o.h = halted; o.t = trap; o.st = state;
    return o;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic e,
                                        input logic l, input logic lu);
    case (f3)
      3'b000:  return e;
      3'b001:  return !e;
      3'b100:  return l;
      3'b101:  return !l;
      3'b110:  return lu;
      3'b111:  return !lu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic add(input vec_t v, input vec_t m, input logic rdy, input logic hr);
    cyc_t c;
    c.v = v; c.m = m; c.rdy = rdy; c.hr = hr;
    q.push_back(c);
  endtask

  // Expected timeline of one instruction
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic e,
                       input logic l, input logic lu, input int fw, input int mw);
    vec_t v, m;
    logic legal, st, last;
    legal = 1'b0;
    foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;
    if (op == 7'b1100011 && (f3 == 3'b010 || f3 == 3'b011)) legal = 1'b0;
    for (int k = 0; k <= fw; k++) begin
      v = '0; v.st = ST_FETCH; v.mq = 1'b1; v.ie = (k == fw);
      m = base_mask(); m.as = 1'b1;
      add(v, m, (k == fw), 1'b0);
    end
    v = '0; v.st = ST_DECODE;
    add(v, base_mask(), rnd(), 1'b0);
    if (!legal) begin
      for (int k = 0; k < 20; k++) begin
        v = '0; v.st = ST_TRAP; v.t = 1'b1;
        add(v, base_mask(), rnd(), rnd());
      end
      return;
    end
    v = '0; v.st = ST_EXEC; m = base_mask();
    if (op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111}) begin
      m.rs = '1; m.aa = 1'b1; m.ab = 1'b1; m.am = '1; m.pas = 1'b1; m.pns = 1'b1;
      v.re = 1'b1; v.pe = 1'b1; v.pas = 1'b1;
    end
    case (op)
      7'b0110011, 7'b0010011: begin v.rs = 2'd1; v.am = 2'd1; v.ab = (op == 7'b0010011); end
      7'b0110111, 7'b0010111: begin v.rs = 2'd1; v.ab = 1'b1; v.aa = (op == 7'b0010111); end
      7'b1101111, 7'b1100111: begin v.ab = 1'b1; v.pns = 1'b1; v.aa = (op == 7'b1101111); end
      7'b1100011: begin
        v.am = 2'd2; v.pe = 1'b1; v.pas = !branch_taken(f3, e, l, lu);
        m.am = '1; m.pas = 1'b1; m.pns = 1'b1;
      end
      7'b0000011, 7'b0100011: begin v.ab = 1'b1; m.aa = 1'b1; m.ab = 1'b1; m.am = '1; end
      default: ;
    endcase
    add(v, m, rnd(), 1'b0);
    if (op == 7'b1110011) begin
      for (int k = 0; k < 8; k++) begin
        v = '0; v.st = ST_HALT; v.h = 1'b1;
        add(v, base_mask(), rnd(), rnd());
      end
      return;
    end
    if (op == 7'b0000011 || op == 7'b0100011) begin
      st = (op == 7'b0100011);
      for (int k = 0; k <= mw; k++) begin
        last = (k == mw);
        v = '0; v.st = ST_MEM; v.mq = 1'b1; v.as = 1'b1; v.mw = st; v.ab = 1'b1;
        v.sx = f3; v.pe = last && st; v.pas = 1'b1;
        m = base_mask(); m.as = 1'b1; m.aa = 1'b1; m.ab = 1'b1; m.am = '1;
        if (last && st) begin m.pas = 1'b1; m.pns = 1'b1; end
        add(v, m, last, 1'b0);
      end
      if (!st) begin
        v = '0; v.st = ST_WB; v.re = 1'b1; v.rs = 2'd2; v.pe = 1'b1; v.pas = 1'b1; v.sx = f3;
        m = base_mask(); m.rs = '1; m.pas = 1'b1; m.pns = 1'b1;
        add(v, m, rnd(), 1'b0);
      end
    end
  endtask

  task automatic build_halt(input int k);
    vec_t v;
    v = '0; v.st = ST_FETCH;
    add(v, base_mask(), rnd(), 1'b1);
    v.st = ST_HALT; v.h = 1'b1;
    for (int i = 0; i < k; i++) add(v, base_mask(), rnd(), 1'b1);
    add(v, base_mask(), rnd(), 1'b0);
  endtask

  // Called in the low clock phase; returns in the low phase of the next cycle
  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      mem_ready = c.rdy;
      halt_req  = c.hr;
      #1;
      chk("ctl", 32'(observe() & c.m), 32'(c.v & c.m));
      chk("cycle_cnt", cycle_cnt, exp_cyc);
      chk("instret_cnt", instret_cnt, exp_ret);
      exp_cyc = exp_cyc + 32'd1;
      exp_ret = exp_ret + {31'd0, c.v.pe};
      @(negedge clk);
    end
  endtask

  task automatic run_insn(input logic [6:0] op, input logic [2:0] f3, input logic e,
                          input logic l, input logic lu, input int fw, input int mw);
    opcode = op; func3 = f3; eq = e; a_lt_b = l; a_lt_ub = lu;
    build(op, f3, e, l, lu, fw, mw);
    run_q();
  endtask

  task automatic do_reset();
    reset = 1'b1; halt_req = 1'b0; mem_ready = 1'b1;
    #1;
    chk("rst_strobes_pre", 32'({insn_en, pc_en, rd_en, mem_req, mem_we}), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'(ST_FETCH));
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_instret", instret_cnt, 32'd0);
    chk("rst_flags", 32'({halted, trap}), 32'd0);
    chk("rst_strobes", 32'({insn_en, pc_en, rd_en, mem_req, mem_we}), 32'd0);
    reset = 1'b0;
    exp_cyc = '0; exp_ret = '0;
    q.delete();
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    opcode = 7'b0010011; func3 = 3'd0; eq = 1'b0; a_lt_b = 1'b0; a_lt_ub = 1'b0;
    do_reset();
    run_insn(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);   // ADDI, zero wait
    run_insn(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 2, 3);   // LW, 10 cycles
    run_insn(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0);   // BNE taken
    run_insn(7'b1100011, 3'b001, 1'b1, 1'b0, 1'b0, 1, 0);   // BNE not taken
    run_insn(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 1);   // SW
    run_insn(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);   // JALR
    run_insn(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1, 0);   // JAL
    build_halt(3);
    run_q();
    for (int i = 0; i < 50; i++) begin
      if (i % 7 == 3) begin
        build_halt(int'($urandom_range(0, 3)));
        run_q();
      end
      op = legal_ops[$urandom_range(0, 8)];
      f3 = 3'($urandom);
      if (op == 7'b1100011 && f3[2:1] == 2'b01) f3[2] = 1'b1;
      run_insn(op, f3, rnd(), rnd(), rnd(),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    // Reset while MEM waits for ready
    opcode = 7'b0000011; func3 = 3'b000;
    build(7'b0000011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 3);
    while (q.size() > 5) void'(q.pop_back());
    run_q();
    do_reset();
    run_insn(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1, 0);   // illegal opcode
    do_reset();
    run_insn(7'b1100011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0);   // illegal branch func3
    do_reset();
    run_insn(7'b0010011, 3'b111, 1'b0, 1'b0, 1'b0, 0, 0);
    run_insn(7'b1110011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);   // ECALL
    do_reset();
    run_insn(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);   // LUI
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multicycle FSM that sequences the single-ported core datapath: instruction fetch, decode, execute, memory access and writeback.
- Drives one-cycle enable strobes that the datapath registers sample on clk, replacing gated clocks.
- Arbitrates the single memory port between fetch (PC address) and load/store (ALU address) using a req/ready handshake.
- Supports halt, sticky illegal-instruction trap, and cycle/instret counters.

Parameters:
CNT_W, 32, width of cycle_cnt and instret_cnt (wrap modulo 2^CNT_W)

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high; overrides everything
opcode  in  7  instruction[6:0]
func3  in  3  instruction[14:12]
eq, a_lt_b, a_lt_ub  in  1 each  ALU compare flags
mem_ready  in  1  memory completes current request this cycle
halt_req  in  1  stop at next instruction boundary
insn_en, pc_en, rd_en  out  1 each  one-cycle load strobes: instruction reg, PC, register file
mem_req, mem_we  out  1 each  memory request / write
addr_sel  out  1  0 = PC, 1 = alu_out
rd_sel  out  2  0 = pc_alu_out, 1 = alu_out, 2 = mem_sx
alu_a_sel, alu_b_sel  out  1 each  0 = rs1/rs2, 1 = pc/imm
alu_mode  out  2  0 = ADD, 1 = from func3/func7, 2 = compare
pc_alu_sel  out  1  0 = imm, 1 = 4
pc_next_sel  out  1  0 = pc_alu_out, 1 = alu_out
sx_size  out  3  func3 during MEM/WB, else 0
halted, trap  out  1 each  status
state  out  3  current state
cycle_cnt, instret_cnt  out  CNT_W each  counters

Behaviour:
- Reset is synchronous, active-high.
  - State goes to FETCH; counters, trap and halted go to 0.
  - While reset is high, all strobes, mem_req and mem_we are forced to 0.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- FETCH: mem_req=1, addr_sel=0. Held until mem_ready.
  - On mem_ready: insn_en=1, go to DECODE.
  - If halt_req is high on entry, go to HALT without issuing mem_req.
- DECODE: one cycle, no strobes; register file read settles.
  - Illegal opcode, or BRANCH with func3 010/011: go to TRAP.
- EXEC: one cycle.
  - OP / OP-IMM: rd_en, rd_sel=1, alu_mode=1, alu_b_sel = (OP-IMM). pc_en with pc_alu_sel=1.
  - LUI / AUIPC: rd_en, rd_sel=1, alu_mode=0, alu_b_sel=1. alu_a_sel=1 for AUIPC; LUI uses rs1 = x0. pc_en with +4.
  - JAL: alu_a_sel=1, alu_b_sel=1, alu_mode=0, pc_next_sel=1 (PC = pc+imm). rd_en, rd_sel=0, pc_alu_sel=1 (rd = pc+4). rd and PC commit on the same edge.
  - JALR: as JAL but alu_a_sel=0. Same-edge commit guarantees rd==rs1 is safe.
  - BRANCH: alu_mode=2, pc_en, pc_next_sel=0, pc_alu_sel = taken ? 0 : 1.
    - taken: BEQ eq, BNE !eq, BLT a_lt_b, BGE !a_lt_b, BLTU a_lt_ub, BGEU !a_lt_ub.
  - LOAD / STORE: alu_mode=0, alu_b_sel=1 (address), no strobes, go to MEM.
  - SYSTEM (ECALL/EBREAK): go to HALT, halted=1, no commit.
  - All other EXEC cases return to FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we = STORE. ALU selects held from EXEC. Held until mem_ready.
  - STORE on ready: pc_en (+4), go to FETCH.
  - LOAD on ready: go to WB.
- WB (LOAD only): rd_en, rd_sel=2, pc_en (+4), go to FETCH. Memory holds dout until the next request.
- mem_req stays high until mem_ready; ready in the request cycle gives zero wait. mem_ready outside FETCH/MEM is ignored.
- Latency with zero wait states: ALU/jump/branch 3 cycles; store 4; load 5.
- HALT: no strobes, halted=1.
  - Reached via halt_req: resume to FETCH when halt_req=0.
  - Reached via SYSTEM: leave only on reset.
- TRAP: trap=1, sticky until reset; no strobes, no mem_req.
- cycle_cnt increments every non-reset cycle, including HALT and TRAP.
- instret_cnt increments on each commit cycle (the pc_en cycle). Both counters wrap.
- Reset mid-transaction (FETCH/MEM waiting): mem_req drops at that edge; no strobe fires.

Decomposition:
- Shared include core_defs.vh holds:
  - state encodings;
  - RV32I opcode constants (0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 1110011);
  - rd_sel and alu_mode encodings.
- One combinational sub-module, branch_resolve: (func3, eq, a_lt_b, a_lt_ub) -> (taken, illegal).

Test Plan:
- Reset, then ADDI with mem_ready tied high → insn_en at cycle 1; rd_en+pc_en in cycle 3 with rd_sel=1, pc_alu_sel=1; instret_cnt=1.
- LW with mem_ready delayed 2 cycles in FETCH and 3 cycles in MEM → mem_req held, addr_sel 0 then 1; WB rd_sel=2, rd_en+pc_en; 10 cycles total.
- BNE with eq=0, then eq=1 → pc_alu_sel=0, then 1; SW → mem_we=1 only in MEM; no rd_en.
- JALR with rd==rs1 → single EXEC cycle with rd_en, pc_en, pc_next_sel=1, rd_sel=0, pc_alu_sel=1.
- Opcode 1111111 → TRAP, trap=1, no further mem_req for 20 cycles; reset clears. halt_req at a boundary → HALT; release → FETCH.
- Reset asserted mid-MEM wait → same edge: mem_req=0, state=FETCH, counters=0.
